// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Shared defaults, source ids and round-robin helper for the
//               register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_REG_IDX = 5;
    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_SRC_W   = 2;

    localparam int SRC_WB  = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    // Pointer successor, wrapping at num_req.
    function automatic int rr_next(input int ptr, input int num_req);
        return (ptr + 1 >= num_req) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter_rr_pick
// Description : Stateless round-robin picker; first valid at or after ptr wins.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   winner,
    output logic               any
);

    int w_best;
    int w_dist;

    // The winner is the valid requester with the smallest forward distance from ptr.
    always_comb begin
        w_best = NUM_REQ;
        w_dist = 0;
        winner = '0;
        grant  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                winner = SRC_W'(i);
            end
        end
        any = (w_best < NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any && (int'(winner) == i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbitration of result producers onto the single
//               register-file write port, with a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_IDX = DEF_REG_IDX,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SRC_W   = DEF_SRC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*REG_IDX-1:0] req_idx,
    input  logic [NUM_REQ*XLEN-1:0]    req_val,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       hold,
    output logic [REG_IDX-1:0]         regFileWriteIdx,
    output logic [XLEN-1:0]            regFileWriteVal,
    output logic                       regFileWriteEn,
    output logic [REG_IDX-1:0]         bp_idx,
    output logic [XLEN-1:0]            bp_val,
    output logic [SRC_W-1:0]           wr_src
);

    logic [NUM_REQ-1:0] w_valid_gated;
    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_winner;
    logic               w_any;
    logic [REG_IDX-1:0] w_sel_idx;
    logic [XLEN-1:0]    w_sel_val;
    logic               w_we;

    logic [SRC_W-1:0]   r_ptr;
    logic               r_valid;
    logic [REG_IDX-1:0] r_idx;
    logic [XLEN-1:0]    r_val;
    logic [SRC_W-1:0]   r_src;

    // Reset is folded in so no handshake can be signalled while the block is held in reset.
    assign w_valid_gated = (hold || !rst) ? '0 : req_valid;

    regfile_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .valid  (w_valid_gated),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_idx = '0;
        w_sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == SRC_W'(i)) begin
                w_sel_idx = req_idx[i*REG_IDX +: REG_IDX];
                w_sel_val = req_val[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_val   <= '0;
            r_src   <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_idx <= w_sel_idx;
                r_val <= w_sel_val;
                r_src <= w_winner;
                r_ptr <= SRC_W'(rr_next(int'(w_winner), NUM_REQ));
            end
        end
    end

    // x0 results are consumed but never reach the register file or bypass bus.
    assign w_we            = r_valid && (r_idx != '0);
    assign regFileWriteEn  = w_we;
    assign regFileWriteIdx = r_idx;
    assign regFileWriteVal = r_val;
    assign wr_src          = r_src;
    assign bp_idx          = w_we ? r_idx : '0;
    assign bp_val          = w_we ? r_val : '0;

endmodule
`default_nettype wire
